reg_file_flags: RTL and testbench

Architectural register file and ALU status register for the 8-bit datapath. Supplies the two ALU operands (DatA, DatB) from a dual-read, single-write array, and captures the ALU status outputs (Zero, Par, SCo) into a flag register. The stored shift carry (SC_IN) feeds back to the ALU for LSH/RSH, and the stored flags go to branch logic. Sits directly upstream of the ALU and also terminates its writeback path.

---
 rtl/reg_file_flags.sv | 96 +++++++++
 tb/tb_reg_file_flags.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_flags.sv
// reg_file_flags
//   Architectural register file and ALU status register for the 8-bit
//   datapath. Two combinational read ports with write-through bypass, one
//   synchronous write port, and a three-bit flag register {SCo, Zero, Par}
//   whose stored shift carry is fed back to the ALU.
//
// Ports
//   Clk       in   system clock, rising edge
//   Reset     in   synchronous active-high reset (clears array and flags)
//   RaddrA/B  in   read addresses, ports A and B
//   DatA/B    out  operands to ALU (combinational, bypassed from Wdat)
//   Wen       in   register write enable
//   Waddr     in   write address
//   Wdat      in   write data
//   FlagWen   in   flag register capture enable
//   ZeroIn    in   ALU Zero
//   ParIn     in   ALU Par
//   SCoIn     in   ALU shift carry-out
//   SC_IN     out  stored shift carry (registered, never bypassed)
//   ZeroQ     out  stored Zero flag
//   ParQ      out  stored Par flag
//
// Wdat reaches DatA/DatB combinationally, so whatever produces Wdat must not
// depend on DatA/DatB in the same cycle.

module reg_file_flags #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [AW-1:0] RaddrA,
  input  logic [AW-1:0] RaddrB,
  output logic [DW-1:0] DatA,
  output logic [DW-1:0] DatB,
  input  logic          Wen,
  input  logic [AW-1:0] Waddr,
  input  logic [DW-1:0] Wdat,
  input  logic          FlagWen,
  input  logic          ZeroIn,
  input  logic          ParIn,
  input  logic          SCoIn,
  output logic          SC_IN,
  output logic          ZeroQ,
  output logic          ParQ
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0] regs [NREG];
  logic          sco_q;
  logic          zero_q;
  logic          par_q;

  logic          hit_a;
  logic          hit_b;

  // Register array. Reset wins over a concurrent write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (Wen) begin
      regs[Waddr] <= Wdat;
    end
  end

  // Flag register, independent of the array write enable.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sco_q  <= 1'b0;
      zero_q <= 1'b0;
      par_q  <= 1'b0;
    end else if (FlagWen) begin
      sco_q  <= SCoIn;
      zero_q <= ZeroIn;
      par_q  <= ParIn;
    end
  end

  // Write-through bypass: a register being written this cycle reads as the
  // incoming data, so back-to-back dependent instructions need no stall.
  assign hit_a = Wen && (Waddr == RaddrA);
  assign hit_b = Wen && (Waddr == RaddrB);

  assign DatA = hit_a ? Wdat : regs[RaddrA];
  assign DatB = hit_b ? Wdat : regs[RaddrB];

  // Shift carry goes back to the ALU only from the stored copy; bypassing
  // SCoIn would close a combinational loop through the ALU.
  assign SC_IN = sco_q;
  assign ZeroQ = zero_q;
  assign ParQ  = par_q;

endmodule

// File: tb/tb_reg_file_flags.sv
module tb_reg_file_flags;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [AW-1:0] RaddrA, RaddrB, Waddr;
  logic [DW-1:0] DatA, DatB, Wdat;
  logic          Wen, FlagWen, ZeroIn, ParIn, SCoIn;
  logic          SC_IN, ZeroQ, ParQ;

  reg_file_flags #(.DW(DW), .AW(AW)) dut (
    .Clk(Clk), .Reset(Reset),
    .RaddrA(RaddrA), .RaddrB(RaddrB), .DatA(DatA), .DatB(DatB),
    .Wen(Wen), .Waddr(Waddr), .Wdat(Wdat),
    .FlagWen(FlagWen), .ZeroIn(ZeroIn), .ParIn(ParIn), .SCoIn(SCoIn),
    .SC_IN(SC_IN), .ZeroQ(ZeroQ), .ParQ(ParQ)
  );

  always #5 Clk = ~Clk;

  // reference state: plain array of register contents and three flag bits
  int unsigned m_reg [NR];
  int unsigned m_sc, m_z, m_p;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full cycle: drive inputs mid-cycle, check the combinational view
  // against the reference, then let the edge happen and update the reference.
  task automatic cyc(input bit rst, input bit wen, input int unsigned wa, input int unsigned wd,
                     input bit fwen, input bit sco, input bit zero, input bit par,
                     input int unsigned ra, input int unsigned rb);
    int unsigned ea, eb;
    @(negedge Clk);
    Reset = rst; Wen = wen; Waddr = AW'(wa); Wdat = DW'(wd);
    FlagWen = fwen; SCoIn = sco; ZeroIn = zero; ParIn = par;
    RaddrA = AW'(ra); RaddrB = AW'(rb);
    #1;
    ea = (wen && wa == ra) ? wd : m_reg[ra];
    eb = (wen && wa == rb) ? wd : m_reg[rb];
    chk("dat_a", DatA, ea);
    chk("dat_b", DatB, eb);
    chk("sc_in", SC_IN, m_sc);
    chk("zero_q", ZeroQ, m_z);
    chk("par_q", ParQ, m_p);
    @(posedge Clk);
    if (rst) begin
      foreach (m_reg[i]) m_reg[i] = 0;
      m_sc = 0; m_z = 0; m_p = 0;
    end else begin
      if (wen) m_reg[wa] = wd;
      if (fwen) begin m_sc = sco; m_z = zero; m_p = par; end
    end
  endtask

  // Idle look with fixed expected constants taken from the test plan.
  task automatic look(input string tag, input int unsigned ra, input int unsigned rb,
                      input int unsigned ea, input int unsigned eb,
                      input int unsigned esc, input int unsigned ez, input int unsigned ep);
    @(negedge Clk);
    Reset = 0; Wen = 0; FlagWen = 0;
    RaddrA = AW'(ra); RaddrB = AW'(rb);
    #1;
    chk({tag, "_a"}, DatA, ea);
    chk({tag, "_b"}, DatB, eb);
    chk({tag, "_sc"}, SC_IN, esc);
    chk({tag, "_z"}, ZeroQ, ez);
    chk({tag, "_p"}, ParQ, ep);
  endtask

  // left shift through carry: result = {r[6:0], cin}, carry-out = r[7]
  task automatic lsh_step(input int unsigned r);
    int unsigned res, co, z, p;
    res = ((r << 1) | m_sc) & 8'hFF;
    co  = (r >> 7) & 1;
    z   = (res == 0) ? 1 : 0;
    p   = $countones(res) & 1;
    cyc(0, 1, 1, res, 1, co[0], z[0], p[0], 0, 0);
  endtask

  initial begin
    Reset = 1; Wen = 0; FlagWen = 0; Waddr = '0; Wdat = '0;
    SCoIn = 0; ZeroIn = 0; ParIn = 0; RaddrA = '0; RaddrB = '0;
    foreach (m_reg[i]) m_reg[i] = 32'hDEAD;  // unknown until reset
    m_sc = 0; m_z = 0; m_p = 0;
    @(posedge Clk);
    foreach (m_reg[i]) m_reg[i] = 0;
    @(posedge Clk);
    look("rst0", 0, 7, 0, 0, 0, 0, 0);

    // reset clears everything
    for (int i = 0; i < NR; i++) cyc(0, 1, i, 8'hAA, 1, 1, 1, 1, i, 0);
    look("pre_rst", 2, 7, 8'hAA, 8'hAA, 1, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NR; i++) look("post_rst", i, NR - 1 - i, 0, 0, 0, 0, 0);

    // write then read
    cyc(0, 1, 3, 8'h5C, 0, 0, 0, 0, 0, 0);
    look("wr3", 3, 3, 8'h5C, 8'h5C, 0, 0, 0);
    look("rd4", 4, 3, 8'h00, 8'h5C, 0, 0, 0);

    // bypass
    cyc(0, 1, 2, 8'h11, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 8'h77, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    Reset = 0; Wen = 1; Waddr = 2; Wdat = 8'h22; FlagWen = 0; RaddrA = 2; RaddrB = 1;
    #1;
    chk("byp_a", DatA, 8'h22);
    chk("byp_b", DatB, 8'h77);
    RaddrB = 2; #1;
    chk("byp_same", DatB, 8'h22);
    @(posedge Clk);
    m_reg[2] = 8'h22;
    look("byp_after", 2, 1, 8'h22, 8'h77, 0, 0, 0);

    // flags capture then hold
    cyc(0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    look("flag_cap", 3, 3, 8'h5C, 8'h5C, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    look("flag_hold", 3, 3, 8'h5C, 8'h5C, 1, 1, 0);

    // reset priority over write and flag capture
    cyc(0, 1, 5, 8'h0F, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 5, 8'hF0, 1, 1, 1, 1, 5, 5);
    look("rst_prio", 5, 3, 0, 0, 0, 0, 0);

    // ALU loop: LSH through carry
    cyc(0, 1, 1, 8'h81, 0, 0, 0, 0, 1, 1);
    lsh_step(m_reg[1]);
    look("lsh1", 1, 1, 8'h02, 8'h02, 1, 0, 1);
    lsh_step(m_reg[1]);
    look("lsh2", 1, 1, 8'h05, 8'h05, 0, 0, 0);

    // randomized traffic against the reference
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, NR - 1),
          $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, NR - 1), $urandom_range(0, NR - 1));
    end
    // sweep the final contents through both ports
    for (int i = 0; i < NR; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, i, NR - 1 - i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
